// File: rtl/mux2_1_32_pkg.sv
// Shared constants and select encoding for the write-back source selector.
package mux2_1_32_pkg;

  localparam int MUX_WIDTH = 32;
  localparam int MUX_CNT_W = 16;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_sel_e;

endpackage

// File: rtl/mux2_core.sv
// Purely combinational 2:1 selector; the selected operand passes bit-exact.
module mux2_core
  import mux2_1_32_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH
) (
  input  wb_sel_e            sel,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   y
);

  // A ternary keeps an unknown select visible as X on the output.
  assign y = (sel == WB_MEM) ? b : a;

endmodule

// File: rtl/mux2_1_32.sv
// Write-back source selector: ALU result vs. memory load data, with
// saturating per-source selection counters.
// Optional registered output stage enabled by macro MUX2_1_32_REG_OUT_EN;
// without it outOp/out_valid are combinational.
module mux2_1_32
  import mux2_1_32_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH,
  parameter int CNT_W = MUX_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemToReg,
  input  logic [WIDTH-1:0] Op1,
  input  logic [WIDTH-1:0] Op2,
  input  logic             in_valid,
  input  logic             stall,
  output logic [WIDTH-1:0] outOp,
  output logic             out_valid,
  output logic [CNT_W-1:0] sel_alu_cnt,
  output logic [CNT_W-1:0] sel_mem_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] sel_data;
  logic             accept;
  logic [CNT_W-1:0] alu_cnt_q;
  logic [CNT_W-1:0] mem_cnt_q;

  assign accept = in_valid & ~stall;

  mux2_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .sel (wb_sel_e'(MemToReg)),
    .a   (Op1),
    .b   (Op2),
    .y   (sel_data)
  );

`ifdef MUX2_1_32_REG_OUT_EN
  logic [WIDTH-1:0] out_q;
  logic             valid_q;

  // Output stage: capture on accept, hold everything on stall, drop valid on bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q <= in_valid;
      if (in_valid) begin
        out_q <= sel_data;
      end
    end
  end

  assign outOp     = out_q;
  assign out_valid = valid_q;
`else
  assign outOp     = sel_data;
  assign out_valid = accept;
`endif

  // Per-source selection counters; each accept bumps exactly one, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_cnt_q <= '0;
      mem_cnt_q <= '0;
    end else if (accept) begin
      if (MemToReg) begin
        if (mem_cnt_q != CNT_MAX) begin
          mem_cnt_q <= mem_cnt_q + CNT_W'(1);
        end
      end else begin
        if (alu_cnt_q != CNT_MAX) begin
          alu_cnt_q <= alu_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign sel_alu_cnt = alu_cnt_q;
  assign sel_mem_cnt = mem_cnt_q;

endmodule

// File: tb/tb_mux2_1_32.sv
// Self-checking bench for mux2_1_32 (works with or without MUX2_1_32_REG_OUT_EN).
module tb_mux2_1_32;

  localparam int WIDTH   = 32;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = 65535;

  logic             clk;
  logic             rst_n;
  logic             MemToReg;
  logic [WIDTH-1:0] Op1;
  logic [WIDTH-1:0] Op2;
  logic             in_valid;
  logic             stall;
  logic [WIDTH-1:0] outOp;
  logic             out_valid;
  logic [CNT_W-1:0] sel_alu_cnt;
  logic [CNT_W-1:0] sel_mem_cnt;

  int num_vectors;
  int num_miscompares;

  // Reference model state: plain integer counts and the last accepted write-back.
  int               alu_count;
  int               mem_count;
  logic [WIDTH-1:0] last_wb;
  logic             last_valid;

  mux2_1_32 #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MemToReg    (MemToReg),
    .Op1         (Op1),
    .Op2         (Op2),
    .in_valid    (in_valid),
    .stall       (stall),
    .outOp       (outOp),
    .out_valid   (out_valid),
    .sel_alu_cnt (sel_alu_cnt),
    .sel_mem_cnt (sel_mem_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_vectors++;
    if (observed !== expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic resetModel();
    alu_count  = 0;
    mem_count  = 0;
    last_wb    = '0;
    last_valid = 1'b0;
  endtask

  task automatic checkAll(input string tag);
    logic [WIDTH-1:0] exp_out;
    logic             exp_valid;
`ifdef MUX2_1_32_REG_OUT_EN
    exp_out   = last_wb;
    exp_valid = last_valid;
`else
    exp_out   = MemToReg ? Op2 : Op1;
    exp_valid = in_valid && !stall;
`endif
    checkOutput({tag, ".outOp"}, outOp, exp_out);
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    checkOutput({tag, ".alu_cnt"}, 32'(sel_alu_cnt), 32'(alu_count));
    checkOutput({tag, ".mem_cnt"}, 32'(sel_mem_cnt), 32'(mem_count));
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(input string tag, input logic sel, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic vld, input logic stl);
    @(negedge clk);
    MemToReg = sel;
    Op1      = a;
    Op2      = b;
    in_valid = vld;
    stall    = stl;
    #1;
    checkAll(tag);
    @(posedge clk);
    if (!stl) begin
      last_valid = vld;
      if (vld) begin
        last_wb = sel ? b : a;
        if (sel) mem_count = (mem_count < CNT_MAX) ? mem_count + 1 : CNT_MAX;
        else     alu_count = (alu_count < CNT_MAX) ? alu_count + 1 : CNT_MAX;
      end
    end
  endtask

  initial begin
    num_vectors     = 0;
    num_miscompares = 0;
    resetModel();
    rst_n    = 1'b0;
    MemToReg = 1'b0;
    Op1      = '0;
    Op2      = '0;
    in_valid = 1'b0;
    stall    = 1'b0;
    #17;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the selection rules.
    applyStimulus("mem_sel", 1'b1, 32'd432, 32'd984, 1'b1, 1'b0);
    applyStimulus("alu_sel", 1'b0, 32'd432, 32'd984, 1'b1, 1'b0);
    applyStimulus("pair_mem", 1'b1, 32'd342, 32'd532, 1'b1, 1'b0);
    applyStimulus("pair_alu", 1'b0, 32'd342, 32'd532, 1'b1, 1'b0);
    applyStimulus("bubble", 1'b1, 32'd7, 32'd9, 1'b0, 1'b0);

    // Accept then stall for three cycles with a changing memory operand.
    applyStimulus("pre_stall", 1'b1, 32'd11, 32'd22, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall", 1'b1, 32'd11, 32'hFFFF_FFFF, 1'b1, 1'b1);
    end
    applyStimulus("post_stall", 1'b0, 32'hA5A5_5A5A, 32'h0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      applyStimulus("rand", 1'($urandom), $urandom, $urandom,
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
    end

    // Drive the memory counter to and past saturation.
    while (mem_count < CNT_MAX) begin
      applyStimulus("fill", 1'b1, $urandom, $urandom, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus("sat", 1'b1, $urandom, $urandom, 1'b1, 1'b0);
    end
    applyStimulus("sat_chk", 1'b0, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    checkOutput("sat_value", 32'(sel_mem_cnt), 32'hFFFF);

    // Asynchronous reset mid-cycle after several accepts.
    for (int i = 0; i < 4; i++) begin
      applyStimulus("pre_rst", 1'(i), 32'hC0DE_0000 + i, 32'hBEEF_0000 + i, 1'b1, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    resetModel();
    #1;
    checkAll("async_rst");
    checkOutput("async_rst.alu_zero", 32'(sel_alu_cnt), 32'd0);
    in_valid = 1'b0;
    stall    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("after_rst", 1'b1, 32'd5, 32'd6, 1'b1, 1'b0);
    applyStimulus("after_rst2", 1'b0, 32'd5, 32'd6, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule
